// File: rtl/npe_seq_pkg.sv
// npe_pkg: shared encodings for the NPE layer sequencer.
//   - mode encodings driven onto o_npe_mode
//   - sequencer state encoding
//   - default counter widths
//   - pe_mask(): MAC-row enable mask derived from mode and krows
package npe_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int TMO_WIDTH_DEF = 8;

  localparam logic [2:0] MODE_CONV = 3'd0;
  localparam logic [2:0] MODE_FC   = 3'd1;
  localparam logic [2:0] MODE_MAX  = 3'd2;
  localparam logic [2:0] MODE_ADD  = 3'd3;
  localparam logic [2:0] MODE_SORT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // conv: thermometer of krows; fc: row 0 only; everything else: no MAC rows.
  function automatic logic [6:0] pe_mask(input logic [2:0] mode, input logic [2:0] krows);
    logic [7:0] therm;
    therm = (8'd1 << krows) - 8'd1;
    case (mode)
      MODE_CONV: pe_mask = therm[6:0];
      MODE_FC:   pe_mask = 7'b0000001;
      default:   pe_mask = 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/npe_seq_cnt.sv
// npe_seq_cnt: loadable up-counter with terminal-count compare.
//   i_clk, i_rst : clock, async active-high reset
//   i_clr        : synchronous clear to zero (priority over i_inc)
//   i_inc        : increment by one
//   i_last       : terminal value
//   o_tc         : current count equals i_last
module npe_seq_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic         o_tc
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == i_last);

endmodule

// File: rtl/npe_seq.sv
// npe_seq: layer-level sequencer for the NPE array.
//   Latches a layer configuration on i_start, pops acc_len beats per output
//   from the source buffer, strobes the mode's output pulse, waits for the
//   NPE result (conv/fc/max) and repeats out_num times, then pulses o_done.
//   Ports: i_clk/i_rst, i_start + i_cfg_* (layer config), i_src_vld/o_src_rdy
//   (buffer pop), o_npe_mode/o_sorter_op/o_mdata_vld/o_wdata_vld/o_pe_en and
//   the four output strobes (NPE controls), i_result_vld (NPE result),
//   o_busy/o_done/o_err (status to layer controller).
module npe_seq
  import npe_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int TMO_WIDTH = TMO_WIDTH_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [2:0]           i_cfg_mode,
  input  logic [2:0]           i_cfg_krows,
  input  logic [CNT_WIDTH-1:0] i_cfg_acc_len,
  input  logic [CNT_WIDTH-1:0] i_cfg_out_num,
  input  logic [4:0]           i_cfg_last_sort_num,
  input  logic                 i_src_vld,
  output logic                 o_src_rdy,
  output logic [2:0]           o_npe_mode,
  output logic                 o_sorter_op,
  output logic                 o_mdata_vld,
  output logic                 o_wdata_vld,
  output logic [6:0]           o_pe_en,
  output logic                 o_pe_conv_out,
  output logic                 o_pe_fc_out,
  output logic                 o_pe_max_out,
  output logic                 o_sorter_out,
  output logic [4:0]           o_last_line_sorter_num,
  input  logic                 i_result_vld,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  // Last FLUSH cycle index before timeout: cycles 0..2^W-2 give 2^W-1 cycles.
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = {{(TMO_WIDTH-1){1'b1}}, 1'b0};

  state_e               state_q, state_d;
  logic [2:0]           mode_q, krows_q;
  logic [CNT_WIDTH-1:0] acc_len_q, out_num_q;
  logic [4:0]           sort_num_q;
  logic                 err_q, err_d;
  logic                 first_q;

  logic cfg_load, cfg_ok, xfer, wait_mode, advance;
  logic beat_tc, out_tc, tmo_tc;

  assign cfg_load  = (state_q == ST_IDLE) && i_start;
  assign xfer      = (state_q == ST_FEED) && i_src_vld;
  assign wait_mode = (mode_q == MODE_CONV) || (mode_q == MODE_FC) || (mode_q == MODE_MAX);
  assign cfg_ok    = (mode_q <= MODE_SORT) && (acc_len_q != '0) && (out_num_q != '0) &&
                     !((mode_q == MODE_CONV) && (krows_q == 3'd0));

  npe_seq_cnt #(.W(CNT_WIDTH)) u_beat_cnt (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_clr((state_q != ST_FEED) || (xfer && beat_tc)),
    .i_inc(xfer),
    .i_last(acc_len_q - ONE),
    .o_tc(beat_tc)
  );

  npe_seq_cnt #(.W(CNT_WIDTH)) u_out_cnt (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_clr(state_q == ST_LOAD),
    .i_inc(advance),
    .i_last(out_num_q - ONE),
    .o_tc(out_tc)
  );

  npe_seq_cnt #(.W(TMO_WIDTH)) u_tmo_cnt (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_clr(state_q != ST_FLUSH),
    .i_inc(state_q == ST_FLUSH),
    .i_last(TMO_LAST),
    .o_tc(tmo_tc)
  );

  // Next-state, error flag and output-advance decode.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cfg_ok) begin
          state_d = ST_FEED;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_FEED: begin
        if (xfer && beat_tc) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_FLUSH: begin
        // A result is taken even on the timeout's last cycle.
        if (!wait_mode || i_result_vld) begin
          advance = 1'b1;
          state_d = out_tc ? ST_DONE : ST_FEED;
        end else if (tmo_tc) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, error and first-flush-cycle registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      first_q <= (state_d == ST_FLUSH) && (state_q != ST_FLUSH);
    end
  end

  // Layer configuration captured on an accepted start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q     <= 3'd0;
      krows_q    <= 3'd0;
      acc_len_q  <= '0;
      out_num_q  <= '0;
      sort_num_q <= 5'd0;
    end else if (cfg_load) begin
      mode_q     <= i_cfg_mode;
      krows_q    <= i_cfg_krows;
      acc_len_q  <= i_cfg_acc_len;
      out_num_q  <= i_cfg_out_num;
      sort_num_q <= i_cfg_last_sort_num;
    end
  end

  assign o_busy                 = (state_q != ST_IDLE);
  assign o_done                 = (state_q == ST_DONE);
  assign o_err                  = err_q;
  assign o_src_rdy              = (state_q == ST_FEED);
  assign o_mdata_vld            = xfer;
  assign o_wdata_vld            = xfer && ((mode_q == MODE_CONV) || (mode_q == MODE_FC) ||
                                           (mode_q == MODE_ADD));
  assign o_npe_mode             = mode_q;
  assign o_last_line_sorter_num = sort_num_q;
  assign o_sorter_op            = o_busy && (mode_q == MODE_SORT);
  assign o_pe_en                = o_busy ? pe_mask(mode_q, krows_q) : 7'd0;
  assign o_pe_conv_out          = first_q && (mode_q == MODE_CONV);
  assign o_pe_fc_out            = first_q && (mode_q == MODE_FC);
  assign o_pe_max_out           = first_q && (mode_q == MODE_MAX);
  // Sorter only strobes on the final output line.
  assign o_sorter_out           = first_q && (mode_q == MODE_SORT) && out_tc;

endmodule

// File: tb/tb_npe_seq.sv
`timescale 1ns/1ps
module tb_npe_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [2:0]  i_cfg_mode, i_cfg_krows;
  logic [15:0] i_cfg_acc_len, i_cfg_out_num;
  logic [4:0]  i_cfg_last_sort_num;
  logic        i_src_vld, i_result_vld;
  logic        o_src_rdy, o_sorter_op, o_mdata_vld, o_wdata_vld;
  logic [2:0]  o_npe_mode;
  logic [6:0]  o_pe_en;
  logic        o_pe_conv_out, o_pe_fc_out, o_pe_max_out, o_sorter_out;
  logic [4:0]  o_last_line_sorter_num;
  logic        o_busy, o_done, o_err;

  always #5 i_clk = ~i_clk;

  npe_seq dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_cfg_mode(i_cfg_mode), .i_cfg_krows(i_cfg_krows),
    .i_cfg_acc_len(i_cfg_acc_len), .i_cfg_out_num(i_cfg_out_num),
    .i_cfg_last_sort_num(i_cfg_last_sort_num),
    .i_src_vld(i_src_vld), .o_src_rdy(o_src_rdy),
    .o_npe_mode(o_npe_mode), .o_sorter_op(o_sorter_op),
    .o_mdata_vld(o_mdata_vld), .o_wdata_vld(o_wdata_vld), .o_pe_en(o_pe_en),
    .o_pe_conv_out(o_pe_conv_out), .o_pe_fc_out(o_pe_fc_out),
    .o_pe_max_out(o_pe_max_out), .o_sorter_out(o_sorter_out),
    .o_last_line_sorter_num(o_last_line_sorter_num),
    .i_result_vld(i_result_vld), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  typedef struct {
    int mode, krows, acc, outn, sortn, vld_pct, lat;
    bit nores;
  } cfg_t;

  typedef struct {
    int beats, n_conv, n_fc, n_max, n_sort, err, pe;
  } exp_t;

  typedef struct {
    cfg_t c;
    exp_t e;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int mode, krows, acc, outn, sortn, vld_pct, lat,
                              input bit nores, input int beats, nconv, nfc, nmax,
                              nsort, err, pe);
    vec_t v;
    v.c.mode = mode; v.c.krows = krows; v.c.acc = acc; v.c.outn = outn;
    v.c.sortn = sortn; v.c.vld_pct = vld_pct; v.c.lat = lat; v.c.nores = nores;
    v.e.beats = beats; v.e.n_conv = nconv; v.e.n_fc = nfc; v.e.n_max = nmax;
    v.e.n_sort = nsort; v.e.err = err; v.e.pe = pe;
    return v;
  endfunction

  // Reference: what a whole layer must produce, from the layer-level rules.
  function automatic exp_t model(input cfg_t c);
    exp_t e;
    bit legal, tmo;
    int strobes;
    legal   = (c.mode <= 4) && (c.acc >= 1) && (c.outn >= 1) &&
              !(c.mode == 0 && (c.krows < 1 || c.krows > 7));
    tmo     = legal && c.nores && (c.mode <= 2);
    e.beats = !legal ? 0 : (tmo ? c.acc : c.acc * c.outn);
    strobes = tmo ? 1 : c.outn;
    e.n_conv = (legal && c.mode == 0) ? strobes : 0;
    e.n_fc   = (legal && c.mode == 1) ? strobes : 0;
    e.n_max  = (legal && c.mode == 2) ? strobes : 0;
    e.n_sort = (legal && c.mode == 4) ? 1 : 0;
    e.err    = (!legal || tmo) ? 1 : 0;
    e.pe     = (c.mode == 0) ? ((1 << c.krows) - 1) : ((c.mode == 1) ? 1 : 0);
    return e;
  endfunction

  task automatic drive_cfg_random();
    i_cfg_mode          = 3'($urandom_range(0, 7));
    i_cfg_krows         = 3'($urandom_range(0, 7));
    i_cfg_acc_len       = 16'($urandom_range(0, 9));
    i_cfg_out_num       = 16'($urandom_range(0, 9));
    i_cfg_last_sort_num = 5'($urandom_range(0, 31));
  endtask

  task automatic run_layer(input cfg_t c, input exp_t e);
    int cyc, beats, since, nconv, nfc, nmax, nsort, done_cyc, strobe_cyc, res_at;
    bit pending, fin, legal, wd_mode, strobe;
    legal   = (e.beats > 0);
    wd_mode = (c.mode == 0) || (c.mode == 1) || (c.mode == 3);
    cyc = 0; beats = 0; since = 0; nconv = 0; nfc = 0; nmax = 0; nsort = 0;
    done_cyc = -1; strobe_cyc = -1; res_at = 0; pending = 1'b0; fin = 1'b0;
    @(negedge i_clk);
    i_start = 1'b1;
    i_cfg_mode = 3'(c.mode); i_cfg_krows = 3'(c.krows);
    i_cfg_acc_len = 16'(c.acc); i_cfg_out_num = 16'(c.outn);
    i_cfg_last_sort_num = 5'(c.sortn);
    i_src_vld = 1'b0; i_result_vld = 1'b0;
    while (!fin) begin
      #1;
      chk("busy", o_busy, (cyc >= 1) ? 1 : 0);
      chk("mdata_vld", o_mdata_vld, o_src_rdy & i_src_vld);
      chk("wdata_vld", o_wdata_vld, wd_mode ? (o_src_rdy & i_src_vld) : 1'b0);
      if (cyc == 1) chk("err_cleared_on_start", o_err, 0);
      if (cyc >= 1) begin
        chk("pe_en", o_pe_en, e.pe);
        chk("npe_mode", o_npe_mode, c.mode);
        chk("sorter_op", o_sorter_op, (c.mode == 4) ? 1 : 0);
        chk("last_sort_num", o_last_line_sorter_num, c.sortn);
      end
      if (!legal || cyc < 2) chk("src_rdy_quiet", o_src_rdy, 0);
      if (o_src_rdy && i_src_vld) begin beats++; since++; end
      strobe = o_pe_conv_out | o_pe_fc_out | o_pe_max_out;
      nconv += o_pe_conv_out; nfc += o_pe_fc_out; nmax += o_pe_max_out;
      nsort += o_sorter_out;
      if (strobe) begin
        chk("beats_per_output", since, c.acc);
        since = 0;
        strobe_cyc = cyc;
        if (!c.nores) begin
          if (c.lat == 0) i_result_vld = 1'b1;
          else begin pending = 1'b1; res_at = cyc + c.lat; end
        end
      end
      if (o_done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else if (cyc >= 3000) begin
        chk("layer_finished", 0, 1);
        fin = 1'b1;
      end else begin
        @(negedge i_clk);
        cyc++;
        i_start   = ($urandom_range(0, 7) == 0);
        drive_cfg_random();
        i_src_vld = ($urandom_range(1, 100) <= c.vld_pct);
        i_result_vld = pending && (cyc == res_at);
        if (i_result_vld) pending = 1'b0;
      end
    end
    chk("beats_total", beats, e.beats);
    chk("n_conv_out", nconv, e.n_conv);
    chk("n_fc_out", nfc, e.n_fc);
    chk("n_max_out", nmax, e.n_max);
    chk("n_sorter_out", nsort, e.n_sort);
    chk("err_at_done", o_err, e.err);
    if (!legal) chk("illegal_done_latency", done_cyc, 2);
    if (legal && e.err == 1) chk("timeout_cycles", done_cyc - strobe_cyc, 255);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_start = 1'b0; i_result_vld = 1'b0;
      i_src_vld = 1'($urandom_range(0, 1));
      #1;
      chk("idle_busy", o_busy, 0);
      chk("idle_done", o_done, 0);
      chk("idle_src_rdy", o_src_rdy, 0);
      chk("err_sticky", o_err, e.err);
    end
  endtask

  vec_t vecs[10];
  cfg_t rc;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_src_vld = 1'b0; i_result_vld = 1'b0;
    i_cfg_mode = 3'd0; i_cfg_krows = 3'd0; i_cfg_acc_len = 16'd0;
    i_cfg_out_num = 16'd0; i_cfg_last_sort_num = 5'd0;
    @(negedge i_clk); @(negedge i_clk);
    #1;
    chk("reset_outputs", {o_busy, o_src_rdy, o_mdata_vld, o_wdata_vld, o_sorter_op,
        o_pe_conv_out, o_pe_fc_out, o_pe_max_out, o_sorter_out, o_done, o_err,
        o_npe_mode, o_pe_en, o_last_line_sorter_num}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    //        mode kr acc out srt vld lat nores beats conv fc max sort err pe
    vecs[0] = mk(0, 3, 4, 2, 0, 100, 2, 0,   8,  2, 0, 0, 0, 0, 7);
    vecs[1] = mk(1, 0, 3, 1, 0,  50, 1, 0,   3,  0, 1, 0, 0, 0, 1);
    vecs[2] = mk(2, 0, 2, 1, 0, 100, 0, 1,   2,  0, 0, 1, 0, 1, 0);
    vecs[3] = mk(0, 3, 0, 2, 0, 100, 0, 0,   0,  0, 0, 0, 0, 1, 7);
    vecs[4] = mk(6, 3, 4, 2, 0, 100, 0, 0,   0,  0, 0, 0, 0, 1, 0);
    vecs[5] = mk(0, 0, 4, 2, 0, 100, 0, 0,   0,  0, 0, 0, 0, 1, 0);
    vecs[6] = mk(4, 0, 2, 3, 17, 70, 0, 0,   6,  0, 0, 0, 1, 0, 0);
    vecs[7] = mk(3, 0, 2, 2, 0, 100, 0, 0,   4,  0, 0, 0, 0, 0, 0);
    vecs[8] = mk(0, 7, 1, 3, 0, 100, 0, 0,   3,  3, 0, 0, 0, 0, 127);
    vecs[9] = mk(1, 2, 3, 0, 0, 100, 0, 0,   0,  0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) run_layer(vecs[i].c, vecs[i].e);

    // Reset in the middle of FEED abandons the layer without o_done.
    @(negedge i_clk);
    i_start = 1'b1; i_cfg_mode = 3'd0; i_cfg_krows = 3'd2;
    i_cfg_acc_len = 16'd5; i_cfg_out_num = 16'd2; i_cfg_last_sort_num = 5'd9;
    i_src_vld = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("feed_before_reset", o_src_rdy, 1);
    i_rst = 1'b1;
    #1;
    chk("reset_mid_feed", {o_busy, o_src_rdy, o_mdata_vld, o_wdata_vld, o_sorter_op,
        o_pe_conv_out, o_pe_fc_out, o_pe_max_out, o_sorter_out, o_done, o_err,
        o_npe_mode, o_pe_en, o_last_line_sorter_num}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      #1;
      chk("no_done_in_reset", o_done, 0);
    end
    @(negedge i_clk);
    i_rst = 1'b0; i_src_vld = 1'b0;
    run_layer(vecs[0].c, vecs[0].e);

    // Randomized layers against the reference model.
    for (int i = 0; i < 30; i++) begin
      rc.mode    = $urandom_range(0, 5);
      rc.krows   = $urandom_range(0, 7);
      rc.acc     = $urandom_range(0, 5);
      rc.outn    = $urandom_range(0, 3);
      rc.sortn   = $urandom_range(0, 31);
      rc.vld_pct = $urandom_range(30, 100);
      rc.lat     = $urandom_range(0, 4);
      rc.nores   = 1'b0;
      run_layer(rc, model(rc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npe_seq.md
Name: npe_seq

Overview:
- Layer-level sequencer for the neural processing element (NPE) array.
- Latches a per-layer configuration on a start pulse, then pops data beats from the feature/weight buffer and drives NPE mode, valid and PE-enable controls.
- Issues the per-output "out" strobe (conv/fc/max/sort), waits for the NPE result before starting the next output, and reports done/error to the top-level controller.
- Sits between the layer controller/buffers and the npe datapath.

Parameters:
- CNT_WIDTH, 16, width of beat and output counters and of the related config fields.
- TMO_WIDTH, 8, width of the result-wait timeout counter; timeout limit is 2^TMO_WIDTH-1 cycles.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  one-cycle start pulse; ignored while o_busy=1
- i_cfg_mode  in  3  0=conv, 1=fc, 2=max, 3=add, 4=sort; 5-7 illegal
- i_cfg_krows  in  3  active MAC rows for conv, legal 1..7
- i_cfg_acc_len  in  CNT_WIDTH  data beats per output, must be >=1
- i_cfg_out_num  in  CNT_WIDTH  outputs per layer, must be >=1
- i_cfg_last_sort_num  in  5  sorter count for the final line
- i_src_vld  in  1  buffer has a beat available
- o_src_rdy  out  1  pop strobe; a beat transfers when i_src_vld&o_src_rdy
- o_npe_mode  out  3  latched mode
- o_sorter_op  out  1  1 while busy in sort mode
- o_mdata_vld  out  1  feature beat valid to NPE
- o_wdata_vld  out  1  weight beat valid to NPE
- o_pe_en  out  7  MAC row enable mask
- o_pe_conv_out, o_pe_fc_out, o_pe_max_out, o_sorter_out  out  1 each  output strobes
- o_last_line_sorter_num  out  5  latched sort count
- i_result_vld  in  1  NPE result valid
- o_busy  out  1  sequencer active
- o_done  out  1  one-cycle layer-complete pulse
- o_err  out  1  sticky error flag

Behaviour:
- Reset (async, i_rst=1):
  - State goes to IDLE; all counters clear.
  - Every output is 0, including o_npe_mode, o_pe_en and o_err.
  - Reset mid-layer abandons the layer; no o_done is issued.
- States: IDLE, LOAD, FEED, FLUSH, DONE.
- IDLE:
  - o_busy=0.
  - i_start=1 latches all i_cfg_* and clears o_err → LOAD.
- LOAD (1 cycle):
  - o_busy=1; derives o_pe_en and checks the config.
  - Illegal config → o_err=1, go to DONE with no beats issued. Illegal means mode>4, acc_len=0, out_num=0, or (conv and krows∉1..7).
  - Legal config → FEED with beat_cnt=0, out_cnt=0.
- o_pe_en, static from LOAD until IDLE:
  - conv: thermometer of krows (krows=3 → 7'b0000111).
  - fc: 7'b0000001.
  - max/add/sort: 0.
- FEED:
  - o_src_rdy=1.
  - o_mdata_vld = i_src_vld (combinational, same cycle as the transfer).
  - o_wdata_vld = i_src_vld for conv/fc/add, else 0.
  - beat_cnt increments on each transfer.
  - The transfer with beat_cnt=acc_len-1 is the last; the next cycle is FLUSH and beat_cnt resets.
  - i_src_vld=0 simply stalls; there is no timeout in FEED.
- FLUSH:
  - o_src_rdy=0.
  - First cycle: one-cycle pulse on the mode's strobe (conv→o_pe_conv_out, fc→o_pe_fc_out, max→o_pe_max_out). Add mode pulses none.
  - Sort mode pulses o_sorter_out only when out_cnt=out_num-1; otherwise no strobe.
  - Then waits for i_result_vld, with the timeout counter running from the strobe cycle.
  - Add and sort do not wait; they advance the cycle after entry.
  - On i_result_vld (or no-wait advance): out_cnt+1; if out_cnt=out_num-1 → DONE, else → FEED.
  - i_result_vld arriving in the strobe cycle itself is accepted.
  - Timeout reaching 2^TMO_WIDTH-1 cycles → o_err=1, DONE.
- DONE:
  - o_done=1 for one cycle, then IDLE.
  - o_err holds until the next accepted i_start.
- i_result_vld outside FLUSH is ignored.
- Counters compare with equality at N-1; there is no wrap within legal ranges.

Decomposition:
- npe_pkg holds:
  - mode encodings: MODE_CONV=0, MODE_FC=1, MODE_MAX=2, MODE_ADD=3, MODE_SORT=4;
  - state encodings;
  - default CNT_WIDTH/TMO_WIDTH.
- Single natural sub-module npe_seq_cnt: loadable up-counter with terminal-count compare, instanced for beat, output and timeout counters.

Test Plan:
- Conv, krows=3, acc_len=4, out_num=2, i_src_vld=1, i_result_vld 2 cycles after each strobe →
  - o_pe_en=7'b0000111;
  - 8 mdata/wdata beats;
  - two o_pe_conv_out pulses;
  - o_done 1 cycle;
  - o_err=0.
- Fc, acc_len=3, i_src_vld toggling 1/0 → o_mdata_vld only on transfer cycles; o_pe_fc_out after exactly 3 beats; o_pe_en=7'b0000001.
- Max, no i_result_vld → o_pe_max_out pulse; o_err=1 after 255 cycles; o_done; o_err stays 1 until next i_start.
- Illegal config (acc_len=0, or mode=6, or conv krows=0) → o_err=1; o_done 2 cycles after start; o_src_rdy never 1.
- Sort, out_num=3, last_sort_num=17 →
  - o_sorter_op=1 while busy;
  - o_sorter_out only on the 3rd flush;
  - o_last_line_sorter_num=17;
  - o_wdata_vld never 1.
- Assert i_rst mid-FEED → all outputs 0 immediately; no o_done; a subsequent start runs a clean layer. A second i_start while busy is ignored.
